// File: rtl/bsg_fsb_hop_out_rr_pkg.sv
// Shared helpers for the round-robin FSB output hop.
package bsg_fsb_hop_out_rr_pkg;

  // clog2 that never returns zero, so single-element vectors stay legal
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fsb_hop_out_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last winner.
module bsg_fsb_hop_out_rr_arb
  import bsg_fsb_hop_out_rr_pkg::*;
#(
  parameter int unsigned chan_p       = 2,
  parameter int unsigned tag_width_lp = safe_clog2(chan_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [chan_p-1:0]       reqs_i,
  input  logic                    en_i,
  output logic [chan_p-1:0]       grant_o,
  output logic [tag_width_lp-1:0] tag_o
);

  logic [tag_width_lp-1:0] last_q;
  logic [tag_width_lp-1:0] last_d;
  logic                    found_c;

  // Scan last+1 .. last+chan_p with modulo wrap so any chan_p works
  always_comb begin
    grant_o = '0;
    tag_o   = '0;
    found_c = 1'b0;
    for (int unsigned i = 1; i <= chan_p; i++) begin
      automatic int unsigned idx = (32'(last_q) + i) % chan_p;
      if (en_i && !found_c && reqs_i[tag_width_lp'(idx)]) begin
        found_c                        = 1'b1;
        grant_o[tag_width_lp'(idx)]    = 1'b1;
        tag_o                          = tag_width_lp'(idx);
      end
    end
  end

  assign last_d = found_c ? tag_o : last_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= tag_width_lp'(chan_p - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One-write/one-read register-file memory with asynchronous read.
module bsg_mem_1r1w
  import bsg_fsb_hop_out_rr_pkg::*;
#(
  parameter int unsigned width_p                = 16,
  parameter int unsigned els_p                  = 2,
  parameter int unsigned read_write_same_addr_p = 0,
  parameter int unsigned addr_width_lp          = safe_clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i && !w_reset_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = r_v_i ? mem_q[r_addr_i] : '0;

  // Reading a word while it is being overwritten is illegal unless allowed
  assert property (@(posedge w_clk_i) disable iff (w_reset_i)
    (read_write_same_addr_p != 0) || !(w_v_i && r_v_i && (w_addr_i == r_addr_i)));

endmodule

// File: rtl/bsg_fsb_hop_out_rr.sv
// N-channel front-side-bus output hop: round-robin grant into an output FIFO.
module bsg_fsb_hop_out_rr
  import bsg_fsb_hop_out_rr_pkg::*;
#(
  parameter int unsigned width_p = 16,
  parameter int unsigned chan_p  = 2,
  parameter int unsigned els_p   = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [chan_p-1:0]           v_i,
  input  logic [chan_p*width_p-1:0]   data_i,
  output logic [chan_p-1:0]           yumi_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_i
);

  localparam int unsigned ptr_w_lp = safe_clog2(els_p);
  localparam int unsigned cnt_w_lp = safe_clog2(els_p + 1);
  localparam int unsigned tag_w_lp = safe_clog2(chan_p);

  logic [ptr_w_lp-1:0] head_q, head_d;
  logic [ptr_w_lp-1:0] tail_q, tail_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                full_q, full_d;

  logic [chan_p-1:0]   grant;
  logic [tag_w_lp-1:0] tag;
  logic                enq;
  logic                deq;
  logic [width_p-1:0]  wdata;

  bsg_fsb_hop_out_rr_arb #(
    .chan_p(chan_p)
  ) arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reqs_i  (v_i),
    .en_i    (!full_q && !reset_i),
    .grant_o (grant),
    .tag_o   (tag)
  );

  assign yumi_o = grant;
  assign enq    = |grant;
  assign v_o    = (count_q != '0) && !reset_i;
  assign deq    = v_o && ready_i;
  assign wdata  = width_p'(data_i >> (32'(tag) * width_p));

  // Pointers wrap naturally since els_p is a power of two
  always_comb begin
    head_d  = deq ? head_q + ptr_w_lp'(1) : head_q;
    tail_d  = enq ? tail_q + ptr_w_lp'(1) : tail_q;
    count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    full_d  = (count_d == cnt_w_lp'(els_p));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  bsg_mem_1r1w #(
    .width_p                (width_p),
    .els_p                  (els_p),
    .read_write_same_addr_p (0)
  ) mem (
    .w_clk_i   (clk_i),
    .w_reset_i (reset_i),
    .w_v_i     (enq),
    .w_addr_i  (tail_q),
    .w_data_i  (wdata),
    .r_v_i     (v_o),
    .r_addr_i  (head_q),
    .r_data_o  (data_o)
  );

  assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(yumi_o));
  assert property (@(posedge clk_i) disable iff (reset_i) (yumi_o & ~v_i) == '0);
  assert property (@(posedge clk_i) disable iff (reset_i) count_q <= cnt_w_lp'(els_p));

endmodule

// File: tb/tb_bsg_fsb_hop_out_rr.sv
// Scoreboard bench for bsg_fsb_hop_out_rr: a 2-channel/2-deep and a 4-channel/4-deep instance.
module tb_bsg_fsb_hop_out_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rdy2, y2_vo;
  logic [1:0]  v2, y2;
  logic [31:0] d2;
  logic [15:0] do2;

  logic        rst4, rdy4, y4_vo;
  logic [3:0]  v4, y4;
  logic [63:0] d4;
  logic [15:0] do4;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q2[$];
  logic [15:0] q4[$];

  bsg_fsb_hop_out_rr #(.width_p(16), .chan_p(2), .els_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst2), .v_i(v2), .data_i(d2), .yumi_o(y2),
    .v_o(y2_vo), .data_o(do2), .ready_i(rdy2)
  );

  bsg_fsb_hop_out_rr #(.width_p(16), .chan_p(4), .els_p(4)) dut4 (
    .clk_i(clk), .reset_i(rst4), .v_i(v4), .data_i(d4), .yumi_o(y4),
    .v_o(y4_vo), .data_o(do4), .ready_i(rdy4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a word leaves the hop
  always @(negedge clk) begin
    #2;
    if (y2_vo && rdy2) begin
      if (q2.size() == 0) chk("dut2 unexpected word", 64'(do2), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("dut2 data_o", 64'(do2), 64'(q2.pop_front()));
    end
  end

  always @(negedge clk) begin
    #2;
    if (y4_vo && rdy4) begin
      if (q4.size() == 0) chk("dut4 unexpected word", 64'(do4), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("dut4 data_o", 64'(do4), 64'(q4.pop_front()));
    end
  end

  // One cycle of stimulus; evo < 0 skips the v_o check
  task automatic s2(input logic rst, input logic [1:0] v, input logic [31:0] d, input logic rdy,
                    input logic [1:0] ey, input int evo, input logic [15:0] w);
    @(negedge clk);
    rst2 = rst; v2 = v; d2 = d; rdy2 = rdy;
    if (rst) q2.delete();
    #1;
    chk("dut2 yumi_o", 64'(y2), 64'(ey));
    if (evo >= 0) chk("dut2 v_o", 64'(y2_vo), 64'(evo));
    if (ey != '0) q2.push_back(w);
  endtask

  task automatic s4(input logic rst, input logic [3:0] v, input logic [63:0] d, input logic rdy,
                    input logic [3:0] ey, input int evo, input logic [15:0] w);
    @(negedge clk);
    rst4 = rst; v4 = v; d4 = d; rdy4 = rdy;
    if (rst) q4.delete();
    #1;
    chk("dut4 yumi_o", 64'(y4), 64'(ey));
    if (evo >= 0) chk("dut4 v_o", 64'(y4_vo), 64'(evo));
    if (ey != '0) q4.push_back(w);
  endtask

  bit exp_g [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int k;
    logic [15:0] w;
    rst2 = 1'b1; v2 = '0; d2 = '0; rdy2 = 1'b0;
    rst4 = 1'b1; v4 = '0; d4 = '0; rdy4 = 1'b0;

    // 2-channel: reset, then alternating grants with both channels requesting
    s2(1, 2'b00, 32'h0, 0, 2'b00, 0, 16'h0);
    s2(1, 2'b00, 32'h0, 0, 2'b00, 0, 16'h0);
    for (int i = 0; i < 6; i++)
      s2(0, 2'b11, {16'hBBBB, 16'hAAAA}, 1, (i % 2 == 0) ? 2'b01 : 2'b10, -1,
         (i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
    s2(0, 2'b00, 32'h0, 1, 2'b00, -1, 16'h0);
    s2(0, 2'b00, 32'h0, 1, 2'b00, -1, 16'h0);

    // Fill to full, single deq, grant only in the following cycle
    s2(0, 2'b01, {16'h0, 16'h1111}, 0, 2'b01, 0, 16'h1111);
    s2(0, 2'b01, {16'h0, 16'h2222}, 0, 2'b01, 1, 16'h2222);
    s2(0, 2'b01, {16'h0, 16'h3333}, 0, 2'b00, 1, 16'h0);
    s2(0, 2'b01, {16'h0, 16'h3333}, 1, 2'b00, 1, 16'h0);
    s2(0, 2'b01, {16'h0, 16'h3333}, 0, 2'b01, 1, 16'h3333);
    s2(0, 2'b01, {16'h0, 16'h4444}, 0, 2'b00, 1, 16'h0);
    s2(0, 2'b00, 32'h0, 1, 2'b00, -1, 16'h0);
    s2(0, 2'b00, 32'h0, 1, 2'b00, -1, 16'h0);
    s2(0, 2'b00, 32'h0, 1, 2'b00, 0, 16'h0);

    // Reset with two words held and both channels requesting
    s2(0, 2'b11, {16'hCCCC, 16'hDDDD}, 0, 2'b10, -1, 16'hCCCC);
    s2(0, 2'b11, {16'hCCCC, 16'hDDDD}, 0, 2'b01, 1, 16'hDDDD);
    s2(0, 2'b11, {16'hCCCC, 16'hDDDD}, 0, 2'b00, 1, 16'h0);
    s2(1, 2'b11, {16'hCCCC, 16'hDDDD}, 0, 2'b00, 0, 16'h0);
    s2(1, 2'b11, {16'hCCCC, 16'hDDDD}, 1, 2'b00, 0, 16'h0);
    s2(0, 2'b11, {16'hEEEE, 16'h5555}, 1, 2'b01, 0, 16'h5555);
    s2(0, 2'b11, {16'hEEEE, 16'h5555}, 1, 2'b10, 1, 16'hEEEE);
    s2(0, 2'b00, 32'h0, 1, 2'b00, -1, 16'h0);
    s2(0, 2'b00, 32'h0, 1, 2'b00, 0, 16'h0);

    // 4-channel: reset, then channels 1 and 3 alternate
    s4(1, 4'b0000, 64'h0, 0, 4'b0000, 0, 16'h0);
    s4(1, 4'b0000, 64'h0, 0, 4'b0000, 0, 16'h0);
    for (int i = 0; i < 4; i++)
      s4(0, 4'b1010, {16'h3003, 16'hDEAD, 16'h1001, 16'hDEAD}, 1,
         (i % 2 == 0) ? 4'b0010 : 4'b1000, -1, (i % 2 == 0) ? 16'h1001 : 16'h3003);
    s4(0, 4'b0000, 64'h0, 1, 4'b0000, -1, 16'h0);
    s4(0, 4'b0000, 64'h0, 1, 4'b0000, 0, 16'h0);

    // FIFO wrap: ten words from channel 0 with ready toggling
    k = 0;
    for (int i = 0; i < 14; i++) begin
      w = 16'h0A00 + 16'(k);
      s4(0, 4'b0001, {48'h0, w}, (i % 2 == 0), exp_g[i] ? 4'b0001 : 4'b0000, -1, w);
      if (exp_g[i]) k++;
    end
    for (int i = 0; i < 5; i++) s4(0, 4'b0000, 64'h0, 1, 4'b0000, -1, 16'h0);

    // Single requester on channel 2
    for (int i = 0; i < 5; i++) begin
      w = 16'h2000 + 16'(i);
      s4(0, 4'b0100, {16'h0, w, 32'h0}, 1, 4'b0100, (i == 0) ? 0 : 1, w);
    end
    s4(0, 4'b0000, 64'h0, 1, 4'b0000, -1, 16'h0);
    s4(0, 4'b0000, 64'h0, 1, 4'b0000, 0, 16'h0);

    @(negedge clk);
    #3;
    chk("dut2 words outstanding", 64'(q2.size()), 64'd0);
    chk("dut4 words outstanding", 64'(q4.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_hop_out_rr.md
Name: bsg_fsb_hop_out_rr

Overview:
- N-channel successor to the fixed two-input front-side-bus output hop.
- Accepts chan_p producer channels, each of width_p bits, and grants one per cycle under round-robin fairness (no fixed priority, no starvation).
- Granted words go into an internal els_p-deep FIFO that drives a single valid/ready output link toward the next hop.

Parameters:
- width_p, 16, payload width per channel and of output.
- chan_p, 2, number of input channels (>=2).
- els_p, 2, output FIFO depth (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  chan_p  per-channel valid.
- data_i  in  chan_p*width_p  channel c occupies bits [c*width_p +: width_p].
- yumi_o  out  chan_p  one-hot-or-zero; channel word consumed this cycle.
- v_o  out  1  output word valid.
- data_o  out  width_p  head-of-FIFO word.
- ready_i  in  1  downstream accepts when v_o & ready_i.

Interface decision (fixed): one clock, clk_i; reset_i is synchronous and active-high.

Behaviour:
- Reset, sampled at posedge:
  - FIFO emptied: count=0, head=0, tail=0.
  - last_grant = chan_p-1, so channel 0 wins first.
  - While reset_i=1: yumi_o=0 and v_o=0.
  - data_o is don't-care when v_o=0.
- full = (count==els_p), registered.
- Arbitration (combinational, same cycle):
  - If !full and |v_i, grant g = first channel with v_i set, scanning last_grant+1, last_grant+2, ... modulo chan_p.
  - yumi_o[g]=1; all other yumi_o bits 0.
  - If full or v_i==0: yumi_o=0 and last_grant is unchanged.
  - yumi_o depends on v_i; producers must not derive v_i from yumi_o.
- On a grant:
  - mem[tail] <= data_i slice g.
  - tail <= tail+1, wrapping at els_p.
  - last_grant <= g.
- Dequeue: deq = v_o & ready_i; head <= head+1, wrapping.
- Output: v_o = (count!=0); data_o = mem[head].
- Count update: count <= count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- Full boundary: no enqueue while full, even if deq occurs in the same cycle (no pass-through). Next grant is possible the cycle after the deq.
- Empty boundary: no bypass. A word enqueued in cycle t appears on v_o/data_o in cycle t+1; minimum latency 1.
- Throughput: one word/cycle sustained when els_p>=2 and ready_i=1.
- Fairness: any channel holding v_i continuously is granted within chan_p grants.
- Producer rule: v_i and data_i must stay stable until yumi_o.
- Reset mid-operation: contents discarded; a grant in the reset cycle is suppressed.
- Widths:
  - head/tail: clog2(els_p) bits.
  - count: clog2(els_p+1) bits.
  - last_grant: clog2(chan_p) bits, with explicit wrap for non-power-of-two chan_p.
- Assertions (simulation only):
  - yumi_o onehot0.
  - No yumi_o[c] without v_i[c].
  - count never exceeds els_p.

Decomposition:
- No shared package typedefs required; widths derive locally from parameters via `BSG_SAFE_CLOG2.
- Sub-module bsg_fsb_hop_out_rr_arb: inputs reqs_i[chan_p], en_i (=!full), clk_i, reset_i; outputs grant_o one-hot and tag_o. It owns last_grant.
- FIFO storage reuses the team's bsg_mem_1r1w (width_p x els_p, read_write_same_addr_p=0). Pointers and count live in the top.

Test Plan:
- Reset, then chan_p=2, v_i=2'b11, data_i={16'hBBBB,16'hAAAA}, ready_i=1 -> yumi_o alternates 01,10,01,...; data_o sequence AAAA,BBBB,AAAA starting one cycle after the first grant.
- chan_p=4, v_i=4'b1010 held, ready_i=1 -> grants 1,3,1,3; yumi_o[0] and yumi_o[2] never set.
- els_p=2, ready_i=0, v_i=01 -> two grants, then yumi_o=0 with v_o=1 held. Raise ready_i for one cycle -> one deq, and the next grant occurs the following cycle, not the same one.
- FIFO wrap: els_p=4, 10 words from channel 0 with ready_i toggling 1,0 -> output order equals input order, with count never exceeding 4.
- Reset asserted with count=2 and v_i=11 -> the following cycle has v_o=0 and yumi_o=0 during reset; first post-reset grant goes to channel 0.
- Single requester: v_i=4'b0100 only, ready_i=1 -> yumi_o=0100 every cycle; data_o tracks channel 2 with 1-cycle latency.
